// File: rtl/la_spram_arb.sv
// la_spram_arb
// Round-robin arbiter that lets N requesters share one single-port RAM.
// Grant, ready and the RAM command are combinational (zero latency); the
// priority pointer and the read-response one-hot are registered.
//
// Ports
//   clk         clock, rising edge
//   nreset      synchronous active-low reset
//   req_valid   per-requester request
//   req_ready   per-requester grant (one-hot or zero)
//   req_we      per-requester write (1) / read (0)
//   req_addr    packed addresses, requester i at [i*AW +: AW]
//   req_din     packed write data
//   req_wmask   packed per-bit write masks
//   resp_valid  one-hot read-data-valid, one cycle after a granted read
//   resp_dout   read data, zero when no response is pending
//   mem_*       single-port RAM command; mem_dout returns one cycle after a read
module la_spram_arb #(
  parameter int N  = 2,
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N-1:0]      req_we,
  input  logic [N*AW-1:0]   req_addr,
  input  logic [N*DW-1:0]   req_din,
  input  logic [N*DW-1:0]   req_wmask,
  output logic [N-1:0]      resp_valid,
  output logic [DW-1:0]     resp_dout,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  output logic [DW-1:0]     mem_wmask,
  input  logic [DW-1:0]     mem_dout
);

  // Keep the pointer at least one bit wide so N=1 still elaborates.
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [N-1:0]  r_resp;

  logic [PW:0]   w_idx;
  logic [N-1:0]  w_pick;
  logic [N-1:0]  w_gnt;
  logic          w_found;
  logic [PW-1:0] w_ptr_nxt;

  // Walk indices ptr, ptr+1, ... (mod N); first valid one wins.
  // Inner loop keeps all vector indexing constant.
  always_comb begin
    w_pick    = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      for (int i = 0; i < N; i++) begin
        if (!w_found && (w_idx == (PW+1)'(i)) && req_valid[i]) begin
          w_found   = 1'b1;
          w_pick[i] = 1'b1;
          w_ptr_nxt = PW'((i + 1) % N);
        end
      end
    end
  end

  // Reset suppresses any grant in the same cycle.
  assign w_gnt     = nreset ? w_pick : '0;
  assign req_ready = w_gnt;

  always_comb begin
    mem_ce    = |w_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    mem_wmask = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        mem_we    = req_we[i];
        mem_addr  = req_addr[i*AW +: AW];
        mem_din   = req_din[i*DW +: DW];
        mem_wmask = req_wmask[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_ptr  <= '0;
      r_resp <= '0;
    end else begin
      if (|w_gnt) r_ptr <= w_ptr_nxt;
      r_resp <= w_gnt & ~req_we;
    end
  end

  // Masking with nreset drops a read whose response would land in a reset cycle.
  assign resp_valid = r_resp & {N{nreset}};
  assign resp_dout  = (|resp_valid) ? mem_dout : '0;

endmodule

// File: doc/la_spram_arb.md
LA_SPRAM_ARB -- requirements
Module: la_spram_arb

Interface
REQ-001 SHALL have parameter N, default 2, the number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 32, the data width.
REQ-003 SHALL have parameter AW, default 10, the address width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port nreset  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port req_valid  input  N  per-requester access request.
REQ-007 SHALL have port req_ready  output  N  per-requester grant; an access transfers when valid and ready are both high.
REQ-008 SHALL have port req_we  input  N  per-requester write (1) or read (0).
REQ-009 SHALL have port req_addr  input  N*AW  addresses; requester i occupies bits [i*AW +: AW].
REQ-010 SHALL have port req_din  input  N*DW  write data, packed as for req_addr.
REQ-011 SHALL have port req_wmask  input  N*DW  per-bit write masks, packed as for req_addr.
REQ-012 SHALL have port resp_valid  output  N  one-hot read-data-valid.
REQ-013 SHALL have port resp_dout  output  DW  read data, shared by all requesters.
REQ-014 SHALL have ports mem_ce, mem_we (1b), mem_addr (AW), mem_din (DW), mem_wmask (DW), all outputs to the single-port RAM.
REQ-015 SHALL have port mem_dout  input  DW  RAM read data, valid one cycle after a read with ce=1.

Function
REQ-016 SHALL grant at most one requester per cycle, round-robin, using a registered priority pointer ptr (0..N-1).
REQ-017 SHALL search for the grant starting at index ptr and ascending modulo N; the first index with req_valid=1 wins.
REQ-018 SHALL drive req_ready combinationally; the winner sees 1 and all others see 0, and req_ready SHALL NOT depend on req_valid of the same requester beyond the arbitration result.
REQ-019 SHALL, on a grant to requester g, drive mem_ce=1, mem_we=req_we[g], and mem_addr, mem_din and mem_wmask from slice g in the same cycle (zero latency).
REQ-020 SHALL drive mem_ce=0, mem_we=0 and mem_wmask=0 when no requester is valid; mem_addr and mem_din are then don't-care.
REQ-021 SHALL update ptr to (g+1) mod N after each grant; ptr SHALL hold when there is no grant.
REQ-022 SHALL, for a granted read in cycle T, assert resp_valid[g]=1 in cycle T+1 only, using a registered one-hot.
REQ-023 SHALL drive resp_dout combinationally from mem_dout, and SHALL drive it to 0 when resp_valid is all zero.
REQ-024 SHALL NOT assert resp_valid for writes.
REQ-025 SHALL sustain back-to-back accesses; a read response in T+1 and a new grant in T+1 SHALL coexist.
REQ-026 SHALL give each continuously valid requester a grant within N cycles (no starvation).
REQ-027 SHALL treat a req_valid deassertion without a grant as a legal withdrawal with no side effects.
REQ-028 SHALL allow N=1; the grant then always equals req_valid[0] and ptr stays 0.

Reset
REQ-029 SHALL, while nreset=0 at a clock edge, set ptr=0 and resp_valid=0.
REQ-030 SHALL force req_ready=0 and mem_ce=0 in any cycle where nreset=0.
REQ-031 SHALL drop a read granted in the cycle before reset asserts; that read produces no resp_valid.

Verification
REQ-032 Reset, then requester 0 writes 0xA5A5A5A5 to address 0x010 with mask all-1, then reads 0x010 -> mem_ce=1 in both cycles, resp_valid=01 one cycle after the read, resp_dout=0xA5A5A5A5.
REQ-033 N=2, both requesters valid for 4 cycles after reset -> grants 0,1,0,1; ptr values 1,0,1,0.
REQ-034 N=4, only requester 3 valid after ptr=1 -> requester 3 is granted that cycle, and next ptr=0.
REQ-035 Requester 1 reads address 5 in cycle T while requester 0 writes in T+1 -> resp_valid=10 in T+1 alongside mem_ce=1, mem_we=1.
REQ-036 Read granted in cycle T, nreset=0 sampled at edge T+1 -> resp_valid stays 0 and the next grant after reset starts from requester 0.
REQ-037 Random traffic from N=4 requesters over 10k cycles against a RAM model -> every read returns the last data written, and no requester waits more than 4 cycles while valid.
